line_array: RTL and testbench



---
 rtl/line_array_if.sv | 42 ++++
 rtl/line_array.sv | 164 ++++++++++++++++
 tb/tb_line_array.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/line_array_if.sv
// ---------------------------------------------------------------------------
// line_array_if
// Request/response bundle between the cache controller (master) and one way
// of cache line storage (slave).
//   index      : entry select for read, write and invalidate
//   read       : capture entry[index] into the registered outputs
//   write      : merge datain into entry[index] under byte_en
//   byte_en    : byte lane enables, bit i covers datain[8i+7:8i]
//   datain     : write data
//   invalidate : clear valid[index]
//   flush      : start a full clear sequence (pulse)
//   dataout    : registered read data
//   valid_out  : registered valid bit of the entry read
//   busy       : clear sequence in progress, all requests ignored
// ---------------------------------------------------------------------------
interface line_array_if #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0]   index;
    logic               read;
    logic               write;
    logic [WIDTH/8-1:0] byte_en;
    logic [WIDTH-1:0]   datain;
    logic               invalidate;
    logic               flush;
    logic [WIDTH-1:0]   dataout;
    logic               valid_out;
    logic               busy;

    modport master (
        output index, read, write, byte_en, datain, invalidate, flush,
        input  dataout, valid_out, busy
    );

    modport slave (
        input  index, read, write, byte_en, datain, invalidate, flush,
        output dataout, valid_out, busy
    );
endinterface

// File: rtl/line_array.sv
// ---------------------------------------------------------------------------
// line_array
// Parametrised cache line storage for one cache way: DEPTH x WIDTH data bits
// plus a valid bit per entry. Byte-merged writes, single-entry invalidate,
// registered read port with write-first forwarding, and a clear sequencer
// that walks every entry after reset or on a flush request.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset (restarts the clear sequence)
//   bus   : line_array_if.slave request/response bundle
// ---------------------------------------------------------------------------
module line_array #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    line_array_if.slave  bus
);
    localparam int NB = WIDTH / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_dataout;
    logic               r_valid_out;

    logic               w_idle;
    logic               w_busy;
    logic               w_wr_en;
    logic               w_inv_en;
    logic               w_rd_en;
    logic [WIDTH-1:0]   w_cur_line;
    logic [WIDTH-1:0]   w_merged;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_rd_valid;

    // State register: reset always lands in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: CLEAR exits after the last entry, flush re-enters.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // Output decode of the state machine.
    always_comb begin
        w_idle = (r_state == ST_IDLE);
        w_busy = (r_state == ST_CLEAR);
    end

    // Clear counter: held at 0 outside CLEAR so every clear starts at entry 0;
    // DEPTH is a power of two, so the increment wraps exactly at DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= {IDX_W{1'b0}};
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + IDX_W'(1);
        end else begin
            r_cnt <= {IDX_W{1'b0}};
        end
    end

    // Request qualification: flush blanks every other request in its cycle,
    // and invalidate beats write.
    always_comb begin
        w_inv_en = w_idle & ~bus.flush & bus.invalidate;
        w_wr_en  = w_idle & ~bus.flush & bus.write & ~bus.invalidate;
        w_rd_en  = w_idle & ~bus.flush & bus.read;
    end

    // Byte-lane merge of write data over the current line contents.
    always_comb begin
        w_cur_line = r_data[bus.index];
        w_merged   = w_cur_line;
        for (int i = 0; i < NB; i++) begin
            if (bus.byte_en[i]) begin
                w_merged[8*i +: 8] = bus.datain[8*i +: 8];
            end else begin
                w_merged[8*i +: 8] = w_cur_line[8*i +: 8];
            end
        end
    end

    // Write-first forwarding: a read sees the entry as updated this cycle.
    always_comb begin
        if (w_wr_en) begin
            w_rd_data = w_merged;
        end else begin
            w_rd_data = w_cur_line;
        end
        if (w_inv_en) begin
            w_rd_valid = 1'b0;
        end else if (w_wr_en) begin
            w_rd_valid = 1'b1;
        end else begin
            w_rd_valid = r_valid[bus.index];
        end
    end

    // Storage update: sequencer clear, merged write, or invalidate.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_data[r_cnt]  <= {WIDTH{1'b0}};
                r_valid[r_cnt] <= 1'b0;
            end else if (w_wr_en) begin
                r_data[bus.index]  <= w_merged;
                r_valid[bus.index] <= 1'b1;
            end else if (w_inv_en) begin
                r_valid[bus.index] <= 1'b0;
            end
        end
    end

    // Registered read port: holds unless an accepted read captures new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dataout   <= {WIDTH{1'b0}};
            r_valid_out <= 1'b0;
        end else if (w_rd_en) begin
            r_dataout   <= w_rd_data;
            r_valid_out <= w_rd_valid;
        end else begin
            r_dataout   <= r_dataout;
            r_valid_out <= r_valid_out;
        end
    end

    assign bus.dataout   = r_dataout;
    assign bus.valid_out = r_valid_out;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_line_array.sv
// ---------------------------------------------------------------------------
// tb_line_array
// Self-checking bench: a byte-array reference model tracks the 128x8 instance
// cycle by cycle under directed and random traffic; a second 32x16 instance
// covers reset during a clear and a narrower byte merge.
// ---------------------------------------------------------------------------
module tb_line_array;
    localparam int W   = 128;
    localparam int D   = 8;
    localparam int NB  = W / 8;
    localparam int W2  = 32;
    localparam int D2  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    line_array_if #(.WIDTH(W),  .DEPTH(D))  bus  ();
    line_array_if #(.WIDTH(W2), .DEPTH(D2)) bus2 ();

    line_array #(.WIDTH(W),  .DEPTH(D))  dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    line_array #(.WIDTH(W2), .DEPTH(D2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]   m_bytes [D][NB];
    logic         m_valid [D];
    logic [W-1:0] m_out;
    logic         m_vout;
    int           m_busy;

    function automatic logic [W-1:0] m_line(int idx);
        logic [W-1:0] l;
        for (int b = 0; b < NB; b++) l[8*b +: 8] = m_bytes[idx][b];
        return l;
    endfunction

    task automatic m_wipe();
        for (int e = 0; e < D; e++) begin
            m_valid[e] = 1'b0;
            for (int b = 0; b < NB; b++) m_bytes[e][b] = 8'h00;
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the main instance, model update, then output check.
    task automatic step(input bit r, input bit w, input bit inv, input bit fl,
                        input int idx, input logic [NB-1:0] be, input logic [W-1:0] din);
        bus.read = r; bus.write = w; bus.invalidate = inv; bus.flush = fl;
        bus.index = 3'(idx); bus.byte_en = be; bus.datain = din;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = D; m_wipe(); m_out = '0; m_vout = 1'b0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (fl) begin
            m_busy = D; m_wipe();
        end else begin
            if (inv) begin
                m_valid[idx] = 1'b0;
            end else if (w) begin
                for (int b = 0; b < NB; b++) if (be[b]) m_bytes[idx][b] = din[8*b +: 8];
                m_valid[idx] = 1'b1;
            end
            if (r) begin
                m_out = m_line(idx); m_vout = m_valid[idx];
            end
        end
        #1;
        chk("busy", W'(bus.busy), W'(m_busy > 0));
        chk("dataout", bus.dataout, m_out);
        chk("valid_out", W'(bus.valid_out), W'(m_vout));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, '0);
    endtask

    // Count cycles busy stays high on the second instance, bounded.
    task automatic count_busy2(output int n);
        n = 0;
        while (bus2.busy && n < 40) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] ones;
        ones = '1;
        rst_n = 1'b0; rst2_n = 1'b0;
        bus.read = 0; bus.write = 0; bus.invalidate = 0; bus.flush = 0;
        bus.index = '0; bus.byte_en = '0; bus.datain = '0;
        bus2.read = 0; bus2.write = 0; bus2.invalidate = 0; bus2.flush = 0;
        bus2.index = '0; bus2.byte_en = '0; bus2.datain = '0;
        m_wipe(); m_out = '0; m_vout = 1'b0; m_busy = D;

        // Reset for two cycles, then the 8-cycle clear
        idle(); idle();
        rst_n = 1'b1;
        repeat (D) idle();
        chk("busy_after_clear", W'(bus.busy), W'(0));
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 1'b0, i, '0, '0);

        // Byte merge on index 3
        step(1'b0, 1'b1, 1'b0, 1'b0, 3, '1, ones);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3, 16'h00F0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3, '0, '0);
        chk("merge_const", bus.dataout, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);

        // Write-first forwarding on index 5
        step(1'b1, 1'b1, 1'b0, 1'b0, 5, '1, 128'h1234);
        chk("fwd_const", bus.dataout, 128'h1234);
        chk("fwd_valid", W'(bus.valid_out), W'(1));

        // Invalidate beats write on index 2
        step(1'b0, 1'b1, 1'b0, 1'b0, 2, '1, {16{8'h55}});
        step(1'b0, 1'b1, 1'b1, 1'b0, 2, '1, {16{8'hAA}});
        step(1'b1, 1'b0, 1'b0, 1'b0, 2, '0, '0);
        chk("inv_data", bus.dataout, {16{8'h55}});
        chk("inv_valid", W'(bus.valid_out), W'(0));

        // Zero byte_en write still sets valid
        step(1'b0, 1'b1, 1'b0, 1'b0, 2, '0, ones);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2, '0, '0);
        chk("be0_valid", W'(bus.valid_out), W'(1));

        // Flush mid-use with writes attempted while busy
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 1'b0, i, '1, {4{$urandom()}});
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, '0, '0);
        for (int i = 0; i < D; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0, '1, ones);
        chk("flush_busy_end", W'(bus.busy), W'(0));
        for (int i = 0; i < D; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, i, '0, '0);
            chk("flush_zero", bus.dataout, '0);
        end

        // Random traffic against the model, with occasional flush/reset
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(149, 0) == 0) rst_n = 1'b0;
            step(1'($urandom_range(1, 0)), ($urandom_range(9, 0) < 4),
                 ($urandom_range(19, 0) < 3), ($urandom_range(49, 0) == 0),
                 $urandom_range(D - 1, 0), 16'($urandom()),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
            rst_n = 1'b1;
        end

        // Second instance: reset release gives exactly 16 busy cycles
        @(posedge clk); #1;
        rst2_n = 1'b1;
        chk("d2_rst_data", W'(bus2.dataout), '0);
        chk("d2_rst_valid", W'(bus2.valid_out), '0);
        count_busy2(n);
        chk("d2_busy_release", W'(n), W'(D2));

        // Flush then reset at clear cycle 5: clear restarts from entry 0
        bus2.flush = 1'b1;
        @(posedge clk); #1;
        bus2.flush = 1'b0;
        chk("d2_flush_busy", W'(bus2.busy), W'(1));
        repeat (5) begin @(posedge clk); #1; end
        rst2_n = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1;
        count_busy2(n);
        chk("d2_busy_midclear", W'(n), W'(D2));

        // Narrow byte merge on the second instance
        bus2.write = 1'b1; bus2.index = 4'd9; bus2.byte_en = 4'b0101;
        bus2.datain = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus2.write = 1'b0; bus2.read = 1'b1;
        @(posedge clk); #1;
        bus2.read = 1'b0;
        chk("d2_merge", W'(bus2.dataout), W'(32'h00AD00EF));
        chk("d2_merge_valid", W'(bus2.valid_out), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
